lt24_response_ctrl: RTL and testbench
=====================================

LT24_RESPONSE_CTRL -- requirements
Module: lt24_response_ctrl

Interface
REQ-001 The block SHALL have parameter FIFO_DEPTH, default 4, giving the response FIFO depth (power of two, 2..16).
REQ-002 The block SHALL have parameter TO_WIDTH, default 16, giving the timeout counter width in bits.
REQ-003 The block SHALL have port clk  input  1  system clock; one clock domain for the whole block.
REQ-004 The block SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 The block SHALL have port address  input  2  Avalon-MM slave word address.
REQ-006 The block SHALL have port read  input  1  Avalon read strobe.
REQ-007 The block SHALL have port write  input  1  Avalon write strobe.
REQ-008 The block SHALL have port writedata  input  32  Avalon write data.
REQ-009 The block SHALL have port readdata  output  32  Avalon read data, registered.
REQ-010 The block SHALL have port resp_data  input  8  response code from the LT24 side.
REQ-011 The block SHALL have port resp_valid  input  1  one-cycle qualifier for resp_data.
REQ-012 The block SHALL have port cmd_start  output  1  one-cycle pulse when a command wait is armed.
REQ-013 The block SHALL have port irq  output  1  level interrupt to the host.

Function
REQ-014 Register map (word addresses): 0 RXDATA, 1 STATUS, 2 CONTROL, 3 ARM.
REQ-015 Read of any register SHALL update readdata on the next clk edge (latency 1); unused bits read 0.
REQ-016 RXDATA read SHALL return {23'b0, valid, head[7:0]} and pop the head entry when the FIFO is non-empty; read when empty SHALL return 0 and change nothing.
REQ-017 STATUS bits: 0 empty, 1 full, 2 overflow (sticky), 3 busy (state WAIT), 4 timeout (sticky), [12:8] FIFO level 0..FIFO_DEPTH.
REQ-018 STATUS write SHALL clear overflow where writedata[2]=1 and timeout where writedata[4]=1 (W1C); other bits are read-only.
REQ-019 CONTROL bits, read/write: 0 irq_en_data, 1 irq_en_timeout, 2 flush (self-clearing, reads 0; empties the FIFO in one cycle).
REQ-020 Every resp_valid cycle SHALL push resp_data, in any FSM state.
REQ-021 Push when full and without a simultaneous pop SHALL drop the data and set overflow.
REQ-022 Push and pop in the same cycle SHALL both succeed at any level, including full and empty: when empty, the pop returns 0 and the push is stored.
REQ-023 If flush and push occur in the same cycle, flush SHALL win; the FIFO ends empty.
REQ-024 FSM states SHALL be IDLE and WAIT.
REQ-025 An ARM write with writedata[TO_WIDTH-1:0] != 0 SHALL: load the counter with that value; enter WAIT; pulse cmd_start on the next cycle. This applies from IDLE or WAIT; a re-arm while in WAIT restarts the count.
REQ-026 An ARM write with value 0 SHALL abort to IDLE, with no cmd_start and no timeout flag.
REQ-027 In WAIT, the counter SHALL decrement by 1 each cycle.
REQ-028 In WAIT, resp_valid SHALL return the FSM to IDLE.
REQ-029 In WAIT, if the counter reaches 0 without resp_valid, the block SHALL set timeout and return to IDLE.
REQ-030 If resp_valid coincides with expiry, the response SHALL win and timeout SHALL stay clear.
REQ-031 If an ARM write coincides with resp_valid, the arm SHALL win: the FSM stays in WAIT and the response is still pushed.
REQ-032 ARM read SHALL return the remaining count (0 in IDLE).
REQ-033 irq SHALL be registered and equal (irq_en_data & !empty) | (irq_en_timeout & timeout).

Reset
REQ-034 While reset is high on a clk edge, the block SHALL: set FSM to IDLE; clear counter, FIFO pointers and level, overflow, timeout, CONTROL, readdata, cmd_start and irq. FIFO storage contents need not be cleared.
REQ-035 Reset asserted mid-WAIT SHALL abort the wait with no timeout flag and no cmd_start.

Structure
REQ-036 The shared package lt24_pkg SHALL hold the register address constants, STATUS/CONTROL bit indices and the FSM state enum.
REQ-037 The FIFO SHALL be a sub-module lt24_resp_fifo (sync FIFO with push, pop, flush, level outputs).

Verification
REQ-038 Scenario: push 0x11, 0x22, 0x33 -> STATUS level=3; RXDATA reads return 0x111, 0x122, 0x133, then 0x000.
REQ-039 Scenario: push 5 codes with FIFO_DEPTH=4 -> full=1, overflow=1; the 5th code is lost; write 0x4 to STATUS -> overflow=0.
REQ-040 Scenario: ARM=10 with no response -> cmd_start pulses once; busy for 10 cycles; then timeout=1; with irq_en_timeout=1, irq=1.
REQ-041 Scenario: ARM=10, resp_valid with 0x5A on the expiry cycle -> timeout=0, state IDLE, FIFO holds 0x5A.
REQ-042 Scenario: full FIFO with simultaneous push 0x77 and RXDATA pop -> level stays 4, no overflow, 0x77 at tail.
REQ-043 Scenario: ARM=100, then reset after 20 cycles -> busy=0, timeout=0, irq=0, ARM read returns 0.

Source files
------------

// File: rtl/lt24_pkg.sv
// Shared definitions for the LT24 response controller: register map,
// STATUS/CONTROL bit positions and the command-wait FSM state type.
package lt24_pkg;

  localparam logic [1:0] ADDR_RXDATA  = 2'd0;
  localparam logic [1:0] ADDR_STATUS  = 2'd1;
  localparam logic [1:0] ADDR_CONTROL = 2'd2;
  localparam logic [1:0] ADDR_ARM     = 2'd3;

  localparam int STAT_EMPTY     = 0;
  localparam int STAT_FULL      = 1;
  localparam int STAT_OVERFLOW  = 2;
  localparam int STAT_BUSY      = 3;
  localparam int STAT_TIMEOUT   = 4;
  localparam int STAT_LEVEL_LSB = 8;
  localparam int STAT_LEVEL_W   = 5;

  localparam int CTRL_IRQ_EN_DATA    = 0;
  localparam int CTRL_IRQ_EN_TIMEOUT = 1;
  localparam int CTRL_FLUSH          = 2;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } state_t;

endpackage

// File: rtl/lt24_resp_fifo.sv
// Synchronous response FIFO with flush; a pop on the same cycle as a push
// frees the slot, so a full FIFO can still accept data when it is read.
module lt24_resp_fifo #(
  parameter  int DEPTH = 4,
  parameter  int WIDTH = 8,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int LVL_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  input  logic             flush,
  output logic [WIDTH-1:0] head,
  output logic             empty,
  output logic             full,
  output logic             dropped,
  output logic [LVL_W-1:0] level
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (level == '0);
  assign full    = (level == LVL_W'(DEPTH));
  assign head    = mem[rd_ptr];
  assign do_pop  = pop && !empty && !flush;
  assign do_push = push && !flush && (!full || do_pop);
  assign dropped = push && !flush && full && !do_pop;

  // NOTE: storage is deliberately not reset; the pointers and level alone say
  // which entries are valid, which keeps the array mappable onto RAM.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      level <= level + LVL_W'(do_push) - LVL_W'(do_pop);
    end
  end

endmodule

// File: rtl/lt24_response_ctrl.sv
// Avalon-MM slave that collects LT24 response codes in a FIFO and times out
// host-armed command waits, raising a level interrupt for data or timeout.
module lt24_response_ctrl
  import lt24_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int TO_WIDTH   = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  address,
  input  logic        read,
  input  logic        write,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  input  logic [7:0]  resp_data,
  input  logic        resp_valid,
  output logic        cmd_start,
  output logic        irq
);

  localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;

  state_t              state;
  logic [TO_WIDTH-1:0] count;
  logic                timeout;
  logic                overflow;
  logic                irq_en_data;
  logic                irq_en_timeout;

  logic [7:0]          fifo_head;
  logic                fifo_empty;
  logic                fifo_full;
  logic                fifo_dropped;
  logic [LVL_W-1:0]    fifo_level;

  logic                rd_rx;
  logic                wr_status;
  logic                wr_control;
  logic                wr_arm;
  logic                flush;
  logic [TO_WIDTH-1:0] arm_value;
  logic [31:0]         status_word;
  logic [31:0]         rd_mux;
  logic                unused_writedata;

  assign rd_rx      = read  && (address == ADDR_RXDATA);
  assign wr_status  = write && (address == ADDR_STATUS);
  assign wr_control = write && (address == ADDR_CONTROL);
  assign wr_arm     = write && (address == ADDR_ARM);
  assign flush      = wr_control && writedata[CTRL_FLUSH];
  assign arm_value  = writedata[TO_WIDTH-1:0];
  assign unused_writedata = &{1'b0, writedata};

  lt24_resp_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (resp_valid),
    .push_data (resp_data),
    .pop       (rd_rx),
    .flush     (flush),
    .head      (fifo_head),
    .empty     (fifo_empty),
    .full      (fifo_full),
    .dropped   (fifo_dropped),
    .level     (fifo_level)
  );

  // NOTE: every variable gets a default first so no path leaves one unassigned
  // and no latch is inferred.
  always_comb begin
    status_word                = '0;
    status_word[STAT_EMPTY]    = fifo_empty;
    status_word[STAT_FULL]     = fifo_full;
    status_word[STAT_OVERFLOW] = overflow;
    status_word[STAT_BUSY]     = (state == ST_WAIT);
    status_word[STAT_TIMEOUT]  = timeout;
    status_word[STAT_LEVEL_LSB +: STAT_LEVEL_W] = STAT_LEVEL_W'(fifo_level);

    rd_mux = '0;
    unique case (address)
      ADDR_RXDATA:  rd_mux = fifo_empty ? 32'd0 : {23'd0, 1'b1, fifo_head};
      ADDR_STATUS:  rd_mux = status_word;
      ADDR_CONTROL: rd_mux = {30'd0, irq_en_timeout, irq_en_data};
      ADDR_ARM:     rd_mux = 32'(count);
      default:      rd_mux = '0;
    endcase
  end

  // Command-wait FSM. An ARM write outranks a coincident response, and a
  // response outranks expiry on the same cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_IDLE;
      count     <= '0;
      timeout   <= 1'b0;
      cmd_start <= 1'b0;
    end else begin
      cmd_start <= 1'b0;
      if (wr_status && writedata[STAT_TIMEOUT]) timeout <= 1'b0;

      if (wr_arm) begin
        if (arm_value != '0) begin
          state     <= ST_WAIT;
          count     <= arm_value;
          cmd_start <= 1'b1;
        end else begin
          state <= ST_IDLE;
          count <= '0;
        end
      end else if (state == ST_WAIT) begin
        if (resp_valid) begin
          state <= ST_IDLE;
          count <= '0;
        end else if (count == TO_WIDTH'(1)) begin
          state   <= ST_IDLE;
          count   <= '0;
          timeout <= 1'b1;
        end else begin
          count <= count - TO_WIDTH'(1);
        end
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      readdata       <= '0;
      overflow       <= 1'b0;
      irq_en_data    <= 1'b0;
      irq_en_timeout <= 1'b0;
      irq            <= 1'b0;
    end else begin
      if (read) readdata <= rd_mux;

      // A drop on the same cycle as the W1C clear leaves the flag set.
      if (wr_status && writedata[STAT_OVERFLOW]) overflow <= 1'b0;
      if (fifo_dropped) overflow <= 1'b1;

      if (wr_control) begin
        irq_en_data    <= writedata[CTRL_IRQ_EN_DATA];
        irq_en_timeout <= writedata[CTRL_IRQ_EN_TIMEOUT];
      end

      irq <= (irq_en_data && !fifo_empty) || (irq_en_timeout && timeout);
    end
  end

endmodule

// File: tb/tb_lt24_response_ctrl.sv
// Directed self-checking bench for lt24_response_ctrl (FIFO_DEPTH=4).
module tb_lt24_response_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [1:0]  address = '0;
  logic        read = 1'b0;
  logic        write = 1'b0;
  logic [31:0] writedata = '0;
  logic [31:0] readdata;
  logic [7:0]  resp_data = '0;
  logic        resp_valid = 1'b0;
  logic        cmd_start;
  logic        irq;

  int checks = 0;
  int errors = 0;

  lt24_response_ctrl #(.FIFO_DEPTH(4), .TO_WIDTH(16)) dut (
    .clk        (clk),
    .reset      (reset),
    .address    (address),
    .read       (read),
    .write      (write),
    .writedata  (writedata),
    .readdata   (readdata),
    .resp_data  (resp_data),
    .resp_valid (resp_valid),
    .cmd_start  (cmd_start),
    .irq        (irq)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish, expected finish before 200us");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one edge; inputs change and outputs are sampled 1 ns after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    address = a; writedata = d; write = 1'b1;
    tick();
    write = 1'b0; writedata = '0;
  endtask

  task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
    address = a; read = 1'b1;
    tick();
    read = 1'b0;
    d = readdata;
  endtask

  task automatic push(input logic [7:0] code);
    resp_data = code; resp_valid = 1'b1;
    tick();
    resp_valid = 1'b0;
  endtask

  task automatic read_check(input string tag, input logic [1:0] a, input logic [31:0] exp);
    logic [31:0] d;
    bus_read(a, d);
    check(tag, d, exp);
  endtask

  initial begin
    logic [31:0] d;
    int busy_cycles;
    int pulses;

    repeat (3) tick();
    reset = 1'b0;
    check("reset_readdata", readdata, 32'h0);
    check("reset_irq", {31'd0, irq}, 32'h0);
    check("reset_cmd_start", {31'd0, cmd_start}, 32'h0);
    read_check("reset_status", 2'd1, 32'h001);
    read_check("reset_arm", 2'd3, 32'h0);

    // Three pushes then drain, including a read of the empty FIFO.
    push(8'h11); push(8'h22); push(8'h33);
    read_check("lvl3_status", 2'd1, 32'h300);
    read_check("rx_11", 2'd0, 32'h111);
    read_check("rx_22", 2'd0, 32'h122);
    read_check("rx_33", 2'd0, 32'h133);
    read_check("rx_empty", 2'd0, 32'h000);
    read_check("drained_status", 2'd1, 32'h001);

    // Overflow: fifth code lost, flag sticky until W1C.
    push(8'hA1); push(8'hA2); push(8'hA3); push(8'hA4); push(8'hA5);
    read_check("ovf_status", 2'd1, 32'h406);
    bus_write(2'd1, 32'h4);
    read_check("ovf_cleared", 2'd1, 32'h402);
    read_check("ovf_rx1", 2'd0, 32'h1A1);
    read_check("ovf_rx2", 2'd0, 32'h1A2);
    read_check("ovf_rx3", 2'd0, 32'h1A3);
    read_check("ovf_rx4", 2'd0, 32'h1A4);
    read_check("ovf_rx5_lost", 2'd0, 32'h000);

    // Full FIFO with simultaneous push and pop.
    push(8'h01); push(8'h02); push(8'h03); push(8'h04);
    address = 2'd0; read = 1'b1; resp_data = 8'h77; resp_valid = 1'b1;
    tick();
    read = 1'b0; resp_valid = 1'b0;
    check("full_pushpop_rx", readdata, 32'h101);
    read_check("full_pushpop_status", 2'd1, 32'h402);
    read_check("full_rx2", 2'd0, 32'h102);
    read_check("full_rx3", 2'd0, 32'h103);
    read_check("full_rx4", 2'd0, 32'h104);
    read_check("full_rx77", 2'd0, 32'h177);

    // Empty FIFO with simultaneous push and pop: pop returns 0, push stored.
    address = 2'd0; read = 1'b1; resp_data = 8'h3C; resp_valid = 1'b1;
    tick();
    read = 1'b0; resp_valid = 1'b0;
    check("empty_pushpop_rx", readdata, 32'h000);
    read_check("empty_pushpop_rx2", 2'd0, 32'h13C);

    // Flush wins over a coincident push.
    push(8'h55); push(8'h66);
    address = 2'd2; writedata = 32'h4; write = 1'b1; resp_data = 8'h99; resp_valid = 1'b1;
    tick();
    write = 1'b0; resp_valid = 1'b0;
    read_check("flush_status", 2'd1, 32'h001);
    read_check("flush_ctrl_reads0", 2'd2, 32'h0);

    // Timeout: ARM=10, no response.
    bus_write(2'd2, 32'h2);
    read_check("ctrl_rw", 2'd2, 32'h2);
    bus_write(2'd3, 32'd10);
    pulses = cmd_start ? 1 : 0;
    busy_cycles = 0;
    for (int i = 0; i < 11; i++) begin
      bus_read(2'd1, d);
      if (d[3]) busy_cycles++;
      if (cmd_start) pulses++;
    end
    check("to_cmd_pulses", 32'(pulses), 32'd1);
    check("to_busy_cycles", 32'(busy_cycles), 32'd10);
    check("to_status", d, 32'h011);
    check("to_irq", {31'd0, irq}, 32'h1);
    read_check("to_arm_idle", 2'd3, 32'h0);
    bus_write(2'd1, 32'h10);
    tick();
    check("to_irq_cleared", {31'd0, irq}, 32'h0);
    read_check("to_cleared_status", 2'd1, 32'h001);

    // Response on the expiry cycle wins over timeout.
    bus_write(2'd3, 32'd10);
    read_check("arm_remaining", 2'd3, 32'd10);
    repeat (8) tick();
    resp_data = 8'h5A; resp_valid = 1'b1;
    tick();
    resp_valid = 1'b0;
    read_check("expiry_resp_status", 2'd1, 32'h100);
    read_check("expiry_rx", 2'd0, 32'h15A);

    // Arm coinciding with a response: stays in WAIT, response stored.
    address = 2'd3; writedata = 32'd3; write = 1'b1; resp_data = 8'h66; resp_valid = 1'b1;
    tick();
    write = 1'b0; resp_valid = 1'b0;
    check("arm_resp_cmd_start", {31'd0, cmd_start}, 32'h1);
    read_check("arm_resp_status", 2'd1, 32'h108);
    bus_write(2'd3, 32'd0);
    check("abort_cmd_start", {31'd0, cmd_start}, 32'h0);
    read_check("abort_status", 2'd1, 32'h100);
    read_check("arm_resp_rx", 2'd0, 32'h166);

    // Data interrupt, then reset in the middle of a long wait.
    bus_write(2'd2, 32'h1);
    push(8'h42);
    tick();
    check("irq_data", {31'd0, irq}, 32'h1);
    bus_write(2'd3, 32'd100);
    repeat (20) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("rst_irq", {31'd0, irq}, 32'h0);
    check("rst_cmd_start", {31'd0, cmd_start}, 32'h0);
    check("rst_readdata", readdata, 32'h0);
    read_check("rst_status", 2'd1, 32'h001);
    read_check("rst_arm", 2'd3, 32'h0);
    read_check("rst_ctrl", 2'd2, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
